cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
Blocking controller for a direct-mapped, one-word-per-line cache. It owns the tag, valid and data arrays and sequences lookups from a single requester. On a miss it refills from backing memory over a req/ack handshake, then returns the word with a hit flag. It also provides a whole-cache flush and saturating hit/miss counters for performance bring-up.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data word width in bits
IDX_W, 3, index bits; number of lines = 2**IDX_W
CNT_W, 16, width of the hit and miss counters

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  request valid; requester holds it and cpu_addr until cpu_ready is seen high
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
cpu_ready  out  1  controller can accept a request this cycle
cpu_valid  out  1  response strobe, exactly one cycle per accepted request
cpu_data  out  DATA_W  response word; valid only when cpu_valid=1
cpu_hit  out  1  1 = served from cache, 0 = refilled; valid only when cpu_valid=1
flush  in  1  pulse; invalidates all lines
mem_req  out  1  backing-memory read request, held until acknowledged
mem_addr  out  ADDR_W  word-aligned read address, bits [1:0]=0
mem_ack  in  1  memory read complete; mem_data valid in the same cycle
mem_data  in  DATA_W  refill word
hit_cnt  out  CNT_W  saturating count of hits
miss_cnt  out  CNT_W  saturating count of misses

Behaviour:
- Address split: index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2].
- Reset (rst=1 at an edge): state goes to IDLE; all valid bits, flush_pend, hit_cnt, miss_cnt, cpu_valid, cpu_hit, cpu_data and mem_req go to 0. cpu_ready=0 while rst=1. Tag and data arrays are not cleared.
- cpu_ready = (state==IDLE) & ~flush_pend & ~flush & ~rst.
- flush_pend is set by flush=1 in any state. It is serviced in IDLE with priority over cpu_req.
- States:
  - IDLE: if flush_pend|flush, go to FLUSH. Otherwise, if cpu_req & cpu_ready, latch the address and go to LOOKUP.
  - FLUSH: one cycle. Clear all valid bits and flush_pend, then go to IDLE. cpu_ready=0.
  - LOOKUP: hit = valid[idx] & tag match.
    - On hit: load cpu_data from the array, cpu_hit=1, increment hit_cnt, go to RESP.
    - On miss: increment miss_cnt, go to MEM_RD.
  - MEM_RD: mem_req=1 and mem_addr = {latched_addr[ADDR_W-1:2],2'b00}, both stable until mem_ack. On mem_ack: write data[idx]=mem_data, tag[idx]=tag, valid[idx]=1; set cpu_data=mem_data, cpu_hit=0; mem_req drops on the next edge; go to RESP.
  - RESP: cpu_valid=1 for one cycle, then go to IDLE.
- Latency:
  - Hit: accept edge at N; cpu_valid high in cycle N+2.
  - Miss: mem_req is high from cycle N+2. With mem_ack in cycle M, cpu_valid is high in cycle M+1.
- Back-to-back: the next request can be accepted in the cycle after RESP (ready returns in IDLE).
- Ignored inputs:
  - mem_ack outside MEM_RD.
  - cpu_req while cpu_ready=0; no state change, no counter change.
- Reset mid-operation (any state): abandon the request. No line is written, no cpu_valid, mem_req=0 next cycle. A late mem_ack is ignored.
- Flush during LOOKUP or MEM_RD: the current request completes normally, including the line write. The flush then executes in IDLE and invalidates that line as well.
- Counters saturate at 2**CNT_W-1 and never wrap.
- Data arrays are registers; no read-before-write hazard exists because the controller is blocking.

Test Plan:
(Memory model returns mem_data = mem_addr>>2 after 3 cycles of mem_req.)
1. Cold misses. After reset, read 0x24 -> mem_req with mem_addr=0x24; cpu_valid with hit=0, data=0x9; miss_cnt=1. Then read 0x34 -> hit=0, data=0xD; miss_cnt=2.
2. Warm hits. Read 0x24 then 0x34 -> hit=1, data 0x9 then 0xD. cpu_valid arrives 2 cycles after each accept; mem_req stays 0; hit_cnt=2.
3. Conflict eviction. Read 0x44 (index 1) -> miss, data=0x11. Then read 0x24 -> miss, data=0x9. Then read 0x34 -> still hit, data=0xD.
4. Flush. Pulse flush, then read 0x24 -> miss, data=0x9. Assert flush and cpu_req in the same IDLE cycle -> cpu_ready=0, FLUSH takes 1 cycle, request accepted 2 cycles later.
5. Reset mid-refill. Assert rst for 1 cycle while mem_req=1, then mem_ack one cycle later -> mem_req=0 after the edge, no cpu_valid, counters=0. Then read 0x24 -> hit=0, data=0x9.
6. Saturation. With CNT_W=2, perform 5 hits on 0x24 -> hit_cnt stays at 3 and does not wrap.

Source files
------------

// File: rtl/cache_ctrl.sv
// Blocking controller for a direct-mapped, one-word-per-line cache.
// Owns the tag/valid/data arrays, refills misses over a req/ack handshake,
// supports a whole-cache flush and keeps saturating hit/miss counters.
module cache_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_hit,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned Lines = 2 ** IDX_W;
  localparam int unsigned TagW  = ADDR_W - IDX_W - 2;

  typedef enum logic [2:0] {StIdle, StFlush, StLookup, StMemRd, StResp} state_e;

  state_e             state_q;
  logic               flush_pend_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [Lines-1:0]   valid_q;
  logic [TagW-1:0]    tag_q  [Lines];
  logic [DATA_W-1:0]  data_q [Lines];
  logic               cpu_valid_q;
  logic               cpu_hit_q;
  logic [DATA_W-1:0]  cpu_data_q;
  logic               mem_req_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic [CNT_W-1:0]   miss_cnt_q;

  logic [IDX_W-1:0]   idx;
  logic [TagW-1:0]    tag;
  logic               hit;

  // Decode the latched request address and evaluate the lookup.
  always_comb begin
    idx = addr_q[IDX_W+1:2];
    tag = addr_q[ADDR_W-1:IDX_W+2];
    hit = valid_q[idx] & (tag_q[idx] == tag);
  end

  // Ready is combinational so a flush or reset blocks acceptance in the same cycle.
  always_comb begin
    cpu_ready = (state_q == StIdle) & ~flush_pend_q & ~flush & ~rst;
  end

  assign cpu_valid = cpu_valid_q;
  assign cpu_hit   = cpu_hit_q;
  assign cpu_data  = cpu_data_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  // Controller FSM with registered outputs; tag and data arrays are never reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      cpu_valid_q  <= 1'b0;
      cpu_hit_q    <= 1'b0;
      cpu_data_q   <= '0;
      mem_req_q    <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      cpu_valid_q <= 1'b0;
      if (flush) flush_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (flush_pend_q || flush) begin
            state_q <= StFlush;
          end else if (cpu_req) begin
            addr_q  <= cpu_addr;
            state_q <= StLookup;
          end
        end
        StFlush: begin
          valid_q      <= '0;
          flush_pend_q <= 1'b0;
          state_q      <= StIdle;
        end
        StLookup: begin
          if (hit) begin
            cpu_data_q  <= data_q[idx];
            cpu_hit_q   <= 1'b1;
            cpu_valid_q <= 1'b1;
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            state_q     <= StResp;
          end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            mem_req_q <= 1'b1;
            state_q   <= StMemRd;
          end
        end
        StMemRd: begin
          if (mem_ack) begin
            data_q[idx]  <= mem_data;
            tag_q[idx]   <= tag;
            valid_q[idx] <= 1'b1;
            cpu_data_q   <= mem_data;
            cpu_hit_q    <= 1'b0;
            cpu_valid_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            state_q      <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios followed by random
// reads, all checked against a line-level cache model kept in the bench.
module tb_cache_ctrl;

  localparam int CntMax = 7;  // CNT_W = 3

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_valid;
  logic [31:0] cpu_data;
  logic        cpu_hit;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [2:0]  hit_cnt;
  logic [2:0]  miss_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: one entry per line, plus the pending-flush flag.
  bit          ref_valid [8];
  logic [26:0] ref_tag   [8];
  int          ref_hits;
  int          ref_misses;
  bit          ref_pend;

  always #5 clk = ~clk;

  cache_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .IDX_W  (3),
    .CNT_W  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_valid (cpu_valid),
    .cpu_data  (cpu_data),
    .cpu_hit   (cpu_hit),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int sat(input int v);
    return (v > CntMax) ? CntMax : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
    ref_pend   = 1'b0;
  endtask

  task automatic model_flush();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    ref_pend = 1'b0;
  endtask

  // One complete read transaction. flush_first asserts flush together with the
  // request; flush_at > 0 pulses flush that many cycles after acceptance.
  task automatic do_read(input logic [31:0] addr, input bit flush_first, input int flush_at);
    int          waits;
    int          exp_wait;
    int          cyc;
    int          req_cycles;
    bit          got;
    bit          exp_hit;
    logic [2:0]  idx;
    logic [26:0] tag;

    exp_wait = (ref_pend || flush_first) ? 2 : 0;
    if (ref_pend || flush_first) model_flush();
    idx     = addr[4:2];
    tag     = addr[31:5];
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    if (exp_hit) ref_hits++;
    else ref_misses++;
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = tag;

    @(negedge clk);
    chk("valid_one_cycle", {63'd0, cpu_valid}, 64'd0);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    flush    = flush_first;
    mem_ack  = 1'b0;
    #1;
    waits = 0;
    while (!cpu_ready && waits < 10) begin
      @(negedge clk);
      flush = 1'b0;
      #1;
      waits++;
    end
    chk("accept_wait", 64'(waits), 64'(exp_wait));

    @(posedge clk);
    cyc        = 0;
    got        = 1'b0;
    req_cycles = 0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      cpu_req = 1'b0;
      flush   = (cyc == flush_at);
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 1) chk("mem_addr", {32'd0, mem_addr}, {32'd0, addr[31:2], 2'b00});
        if (req_cycles == 3) begin
          mem_ack  = 1'b1;
          mem_data = mem_addr >> 2;
        end
      end
      if (cpu_valid) got = 1'b1;
    end
    chk("resp_seen", {63'd0, got}, 64'd1);
    chk("hit_flag", {63'd0, cpu_hit}, {63'd0, exp_hit});
    chk("data", {32'd0, cpu_data}, {32'd0, 2'b00, addr[31:2]});
    chk("latency", 64'(cyc), exp_hit ? 64'd2 : 64'd5);
    chk("mem_req_cycles", 64'(req_cycles), exp_hit ? 64'd0 : 64'd3);
    chk("hit_cnt", {61'd0, hit_cnt}, 64'(sat(ref_hits)));
    chk("miss_cnt", {61'd0, miss_cnt}, 64'(sat(ref_misses)));

    if (flush_at > 0) model_flush_after_resp();
  endtask

  // A flush seen mid-request invalidates everything once the request retires.
  task automatic model_flush_after_resp();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    ref_pend = 1'b1;
  endtask

  initial begin
    int          w;
    bit          sawv;
    logic [26:0] t;
    logic [31:0] a;
    bit          ff;
    int          fa;

    rst      = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    mem_ack  = 1'b0;
    mem_data = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, cpu_ready}, 64'd0);
    chk("rst_valid", {63'd0, cpu_valid}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_hit", {63'd0, cpu_hit}, 64'd0);
    chk("rst_data", {32'd0, cpu_data}, 64'd0);
    chk("rst_hit_cnt", {61'd0, hit_cnt}, 64'd0);
    chk("rst_miss_cnt", {61'd0, miss_cnt}, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, cpu_ready}, 64'd1);

    // Cold misses, warm hits, conflict eviction
    do_read(32'h24, 1'b0, 0);
    do_read(32'h34, 1'b0, 0);
    do_read(32'h24, 1'b0, 0);
    do_read(32'h34, 1'b0, 0);
    do_read(32'h44, 1'b0, 0);
    do_read(32'h24, 1'b0, 0);
    do_read(32'h34, 1'b0, 0);

    // Standalone flush pulse in IDLE
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_blocks_ready", {63'd0, cpu_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_state_ready", {63'd0, cpu_ready}, 64'd0);
    model_flush();
    do_read(32'h24, 1'b0, 0);
    // Flush together with a request, then flushes landing mid-request
    do_read(32'h34, 1'b1, 0);
    do_read(32'h44, 1'b0, 3);
    do_read(32'h44, 1'b0, 0);
    do_read(32'h44, 1'b0, 1);
    do_read(32'h44, 1'b0, 0);

    // Reset in the middle of a refill, with a late acknowledge
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 32'h24;
    #1;
    chk("rr_ready", {63'd0, cpu_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    w = 0;
    while (!mem_req && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("rr_req_seen", {63'd0, mem_req}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rr_ready_in_rst", {63'd0, cpu_ready}, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    mem_ack  = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    chk("rr_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rr_hit_cnt", {61'd0, hit_cnt}, 64'd0);
    chk("rr_miss_cnt", {61'd0, miss_cnt}, 64'd0);
    sawv = cpu_valid;
    repeat (4) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (cpu_valid || mem_req) sawv = 1'b1;
    end
    chk("rr_quiet", {63'd0, sawv}, 64'd0);
    model_reset();
    do_read(32'h24, 1'b0, 0);

    // Saturation of the hit counter
    repeat (9) do_read(32'h24, 1'b0, 0);

    // Random traffic over a few tags so that hits, misses and evictions mix
    for (int i = 0; i < 60; i++) begin
      t  = ($urandom_range(0, 7) == 0) ? 27'($urandom) : 27'($urandom_range(0, 3));
      a  = {t, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      ff = ($urandom_range(0, 15) == 0);
      fa = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_read(a, ff, fa);
    end

    @(negedge clk);
    flush = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
